instr_encoder_loader: RTL and testbench

- Inverse of the instruction decoder: accepts symbolic instruction fields (format class, 4-bit ALU op code, funct3, registers, immediate) and assembles legal RV32I 32-bit words.
- Writes each word sequentially into instruction memory through a handshaked write port.
- Used by self-test and boot sequences to build programs in imem without an external assembler.
- Illegal field combinations are flagged and never written.

---
 rtl/instr_encoder_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Assembles RV32I instruction words from symbolic fields and streams them
// into instruction memory through a valid/ready write port.
module instr_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_BASE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_last,
  input  logic [2:0]        i_fmt,
  input  logic [3:0]        i_alu_op,
  input  logic [2:0]        i_f3,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  output logic              o_imem_we,
  input  logic              i_imem_ready,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [15:0]       o_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_err_index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_IALU   = 3'd1;
  localparam logic [2:0] FMT_LOAD   = 3'd2;
  localparam logic [2:0] FMT_STORE  = 3'd3;
  localparam logic [2:0] FMT_BRANCH = 3'd4;
  localparam logic [2:0] FMT_JAL    = 3'd5;
  localparam logic [2:0] FMT_JALR   = 3'd6;
  localparam logic [2:0] FMT_U      = 3'd7;

  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_LUI   = 4'b1100;
  localparam logic [3:0] OP_AUIPC = 4'b1101;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [15:0]       r_count;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_errIndex;

  logic              w_inReady;
  logic              w_doneNext;
  logic              w_accept;
  logic              w_retire;

  logic [2:0]        w_aluF3;
  logic [6:0]        w_aluF7;
  logic              w_aluOk;
  logic              w_isShift;
  logic              w_imm12Ok;
  logic              w_imm13Ok;
  logic              w_imm21Ok;
  logic [31:0]       w_word;
  logic              w_legal;

  // ALU op code to funct3/funct7; LUI, AUIPC and unused codes have no R/I form.
  always_comb begin
    w_aluF3   = 3'b000;
    w_aluF7   = 7'b0000000;
    w_aluOk   = 1'b1;
    w_isShift = 1'b0;
    case (i_alu_op)
      4'b0000: w_aluF3 = 3'b111;
      4'b0001: w_aluF3 = 3'b110;
      4'b0010: w_aluF3 = 3'b000;
      4'b0011: begin
        w_aluF3   = 3'b001;
        w_isShift = 1'b1;
      end
      4'b0100: begin
        w_aluF3 = 3'b000;
        w_aluF7 = 7'b0100000;
      end
      4'b0101: begin
        w_aluF3   = 3'b101;
        w_isShift = 1'b1;
      end
      4'b0110: w_aluF3 = 3'b011;
      4'b0111: w_aluF3 = 3'b100;
      4'b1000: w_aluF3 = 3'b010;
      4'b1001: begin
        w_aluF3   = 3'b101;
        w_aluF7   = 7'b0100000;
        w_isShift = 1'b1;
      end
      default: w_aluOk = 1'b0;
    endcase
  end

  assign w_imm12Ok = (&i_imm[31:11]) || (~|i_imm[31:11]);
  assign w_imm13Ok = (&i_imm[31:12]) || (~|i_imm[31:12]);
  assign w_imm21Ok = (&i_imm[31:20]) || (~|i_imm[31:20]);

  always_comb begin
    w_word  = 32'h0000_0000;
    w_legal = 1'b0;
    case (i_fmt)
      FMT_R: begin
        w_word  = {w_aluF7, i_rs2, i_rs1, w_aluF3, i_rd, 7'b0110011};
        w_legal = w_aluOk;
      end
      FMT_IALU: begin
        if (w_isShift) begin
          w_word  = {w_aluF7, i_imm[4:0], i_rs1, w_aluF3, i_rd, 7'b0010011};
          w_legal = w_aluOk && (~|i_imm[31:5]);
        end else begin
          w_word  = {i_imm[11:0], i_rs1, w_aluF3, i_rd, 7'b0010011};
          w_legal = w_aluOk && (i_alu_op != OP_SUB) && w_imm12Ok;
        end
      end
      FMT_LOAD: begin
        w_word  = {i_imm[11:0], i_rs1, i_f3, i_rd, 7'b0000011};
        w_legal = w_imm12Ok && (i_f3 != 3'b011) && (i_f3 != 3'b110) &&
                  (i_f3 != 3'b111);
      end
      FMT_STORE: begin
        w_word  = {i_imm[11:5], i_rs2, i_rs1, i_f3, i_imm[4:0], 7'b0100011};
        w_legal = w_imm12Ok && (i_f3 <= 3'b010);
      end
      FMT_BRANCH: begin
        w_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_f3, i_imm[4:1],
                   i_imm[11], 7'b1100011};
        w_legal = (i_f3 != 3'b010) && (i_f3 != 3'b011) && !i_imm[0] &&
                  w_imm13Ok;
      end
      FMT_JAL: begin
        w_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd,
                   7'b1101111};
        w_legal = !i_imm[0] && w_imm21Ok;
      end
      FMT_JALR: begin
        w_word  = {i_imm[11:0], i_rs1, 3'b000, i_rd, 7'b1100111};
        w_legal = w_imm12Ok;
      end
      FMT_U: begin
        w_word  = {i_imm[31:12], i_rd,
                   (i_alu_op == OP_AUIPC) ? 7'b0010111 : 7'b0110111};
        w_legal = (~|i_imm[11:0]) &&
                  ((i_alu_op == OP_LUI) || (i_alu_op == OP_AUIPC));
      end
      default: begin
        w_word  = 32'h0000_0000;
        w_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // LAST waits for any word still in the output register before signalling done.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_doneNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_inReady = !r_we || i_imem_ready;
        if (w_inReady && i_in_valid && i_in_last) begin
          w_nextState = LAST;
        end
      end
      LAST: begin
        if (!r_we || i_imem_ready) begin
          w_doneNext  = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_accept = w_inReady && i_in_valid;
  assign w_retire = r_we && i_imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_addr     <= RESET_BASE;
      r_wdata    <= 32'h0000_0000;
      r_count    <= 16'h0000;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_errIndex <= 16'h0000;
    end else begin
      r_done <= w_doneNext;
      if ((r_state == IDLE) && i_start) begin
        r_addr     <= {i_base_addr[ADDR_W-1:2], 2'b00};
        r_count    <= 16'h0000;
        r_err      <= 1'b0;
        r_errIndex <= 16'h0000;
      end else begin
        if (w_retire) begin
          r_addr <= r_addr + ADDR_W'(4);
          if (r_count != 16'hFFFF) begin
            r_count <= r_count + 16'h0001;
          end
        end
        if (w_accept && !w_legal) begin
          r_err <= 1'b1;
          if (!r_err) begin
            r_errIndex <= r_count;
          end
        end
      end
      // A new word may load in the same cycle the previous one retires.
      if (w_accept && w_legal) begin
        r_we    <= 1'b1;
        r_wdata <= w_word;
      end else if (w_retire) begin
        r_we <= 1'b0;
      end
    end
  end

  assign o_in_ready   = w_inReady;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_count      = r_count;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_err_index  = r_errIndex;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: hand-assembled RV32I words,
// backpressure, illegal-field dropping, address wrap and mid-run reset.
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] baseAddr;
  logic        start2;
  logic [7:0]  baseAddr2;
  logic        inValid;
  logic        inLast;
  logic [2:0]  fmt;
  logic [3:0]  aluOp;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        imemReady;

  logic        inReady1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic [15:0] count1;
  logic        busy1;
  logic        done1;
  logic        err1;
  logic [15:0] errIndex1;

  logic        inReady2;
  logic        we2;
  logic [7:0]  addr2;
  logic [31:0] wdata2;
  logic [15:0] count2;
  logic        busy2;
  logic        done2;
  logic        err2;
  logic [15:0] errIndex2;

  int vectors = 0;
  int miss    = 0;

  logic [31:0] wrAddr1[$];
  logic [31:0] wrData1[$];
  logic [31:0] wrAddr2[$];
  logic [31:0] wrData2[$];

  instr_encoder_loader #(.ADDR_W(32), .RESET_BASE(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(baseAddr),
    .i_in_valid(inValid), .o_in_ready(inReady1), .i_in_last(inLast),
    .i_fmt(fmt), .i_alu_op(aluOp), .i_f3(f3), .i_rd(rd), .i_rs1(rs1),
    .i_rs2(rs2), .i_imm(imm), .o_imem_we(we1), .i_imem_ready(imemReady),
    .o_imem_addr(addr1), .o_imem_wdata(wdata1), .o_count(count1),
    .o_busy(busy1), .o_done(done1), .o_err(err1), .o_err_index(errIndex1)
  );

  instr_encoder_loader #(.ADDR_W(8), .RESET_BASE(8'h0)) u_dutWrap (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .i_base_addr(baseAddr2),
    .i_in_valid(inValid), .o_in_ready(inReady2), .i_in_last(inLast),
    .i_fmt(fmt), .i_alu_op(aluOp), .i_f3(f3), .i_rd(rd), .i_rs1(rs1),
    .i_rs2(rs2), .i_imm(imm), .o_imem_we(we2), .i_imem_ready(imemReady),
    .o_imem_addr(addr2), .o_imem_wdata(wdata2), .o_count(count2),
    .o_busy(busy2), .o_done(done2), .o_err(err2), .o_err_index(errIndex2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (rst_n && we1 && imemReady) begin
      wrAddr1.push_back(addr1);
      wrData1.push_back(wdata1);
    end
    if (rst_n && we2 && imemReady) begin
      wrAddr2.push_back({24'h0, addr2});
      wrData2.push_back(wdata2);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miss++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input bit sel, input int idx, input logic [31:0] expAddr,
                            input logic [31:0] expData);
    logic [31:0] obsAddr;
    logic [31:0] obsData;
    obsAddr = 32'hxxxx_xxxx;
    obsData = 32'hxxxx_xxxx;
    if (!sel && idx < wrAddr1.size()) begin
      obsAddr = wrAddr1[idx];
      obsData = wrData1[idx];
    end else if (sel && idx < wrAddr2.size()) begin
      obsAddr = wrAddr2[idx];
      obsData = wrData2[idx];
    end
    checkOutput("write_addr", obsAddr, expAddr);
    checkOutput("write_data", obsData, expData);
  endtask

  // Presents one set of fields and holds them until the selected encoder takes them.
  task automatic applyStimulus(input bit sel, input logic [2:0] f, input logic [3:0] op,
                               input logic [2:0] fn3, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic [31:0] im, input bit last);
    int waitCnt;
    fmt     = f;
    aluOp   = op;
    f3      = fn3;
    rd      = d;
    rs1     = s1;
    rs2     = s2;
    imm     = im;
    inLast  = last;
    inValid = 1'b1;
    #1;
    waitCnt = 0;
    while (!(sel ? inReady2 : inReady1) && waitCnt < 50) begin
      step();
      waitCnt++;
    end
    checkOutput("accept_wait", (waitCnt < 50) ? 32'd1 : 32'd0, 32'd1);
    step();
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic pulseStart(input logic [31:0] base);
    start    = 1'b1;
    baseAddr = base;
    step();
    start = 1'b0;
  endtask

  int mark;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    baseAddr  = 32'h0;
    start2    = 1'b0;
    baseAddr2 = 8'h0;
    inValid   = 1'b0;
    inLast    = 1'b0;
    fmt       = 3'd0;
    aluOp     = 4'd0;
    f3        = 3'd0;
    rd        = 5'd0;
    rs1       = 5'd0;
    rs2       = 5'd0;
    imm       = 32'h0;
    imemReady = 1'b1;

    #2;
    checkOutput("rst_we", {31'h0, we1}, 32'h0);
    checkOutput("rst_addr", addr1, 32'h0);
    checkOutput("rst_wdata", wdata1, 32'h0);
    checkOutput("rst_count", {16'h0, count1}, 32'h0);
    checkOutput("rst_err", {31'h0, err1}, 32'h0);
    checkOutput("rst_err_index", {16'h0, errIndex1}, 32'h0);
    checkOutput("rst_done", {31'h0, done1}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, inReady1}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy1}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] normal write sequence");
    mark     = wrAddr1.size();
    start    = 1'b1;
    baseAddr = 32'h0000_0102;
    fmt = 3'd0; aluOp = 4'b0010; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2;
    inValid  = 1'b1;
    #1;
    checkOutput("idle_in_ready", {31'h0, inReady1}, 32'h0);
    step();
    start   = 1'b0;
    inValid = 1'b0;
    checkOutput("start_no_accept", {31'h0, we1}, 32'h0);
    checkOutput("start_addr", addr1, 32'h0000_0100);
    checkOutput("start_busy", {31'h0, busy1}, 32'h1);
    applyStimulus(0, 3'd0, 4'b0010, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
    checkOutput("add_we", {31'h0, we1}, 32'h1);
    checkOutput("add_wdata", wdata1, 32'h0020_81B3);
    applyStimulus(0, 3'd1, 4'b0010, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    checkOutput("addi_addr", addr1, 32'h0000_0104);
    checkOutput("addi_wdata", wdata1, 32'h0050_0093);
    checkOutput("addi_done_early", {31'h0, done1}, 32'h0);
    step();
    checkOutput("seq_done", {31'h0, done1}, 32'h1);
    checkOutput("seq_count", {16'h0, count1}, 32'd2);
    checkOutput("seq_idle", {31'h0, busy1}, 32'h0);
    step();
    checkOutput("seq_done_pulse", {31'h0, done1}, 32'h0);
    checkWrite(0, mark + 0, 32'h0000_0100, 32'h0020_81B3);
    checkWrite(0, mark + 1, 32'h0000_0104, 32'h0050_0093);

    $display("[TB] remaining formats");
    mark = wrAddr1.size();
    pulseStart(32'h0000_0200);
    applyStimulus(0, 3'd0, 4'b1001, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0, 0);
    applyStimulus(0, 3'd7, 4'b1100, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5000, 0);
    applyStimulus(0, 3'd3, 4'b0000, 3'b010, 5'd0, 5'd1, 5'd2, 32'd4, 0);
    applyStimulus(0, 3'd4, 4'b0000, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8, 0);
    applyStimulus(0, 3'd5, 4'b0000, 3'b000, 5'd1, 5'd0, 5'd0, 32'd16, 1);
    step();
    checkOutput("fmt_done", {31'h0, done1}, 32'h1);
    checkOutput("fmt_count", {16'h0, count1}, 32'd5);
    checkWrite(0, mark + 0, 32'h0000_0200, 32'h4073_52B3);
    checkWrite(0, mark + 1, 32'h0000_0204, 32'h1234_5537);
    checkWrite(0, mark + 2, 32'h0000_0208, 32'h0020_A223);
    checkWrite(0, mark + 3, 32'h0000_020C, 32'h0020_8463);
    checkWrite(0, mark + 4, 32'h0000_0210, 32'h0100_00EF);

    $display("[TB] backpressure");
    step();
    mark = wrAddr1.size();
    pulseStart(32'h0000_0300);
    imemReady = 1'b0;
    applyStimulus(0, 3'd0, 4'b0111, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 0);
    fmt = 3'd1; aluOp = 4'b0010; rd = 5'd2; rs1 = 5'd2; imm = 32'hFFFF_FFFF;
    inLast  = 1'b1;
    inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_in_ready", {31'h0, inReady1}, 32'h0);
      checkOutput("bp_we", {31'h0, we1}, 32'h1);
      checkOutput("bp_addr", addr1, 32'h0000_0300);
      checkOutput("bp_wdata", wdata1, 32'h0031_40B3);
      step();
    end
    imemReady = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'h0, inReady1}, 32'h1);
    step();
    inValid = 1'b0;
    inLast  = 1'b0;
    checkOutput("bp_next_addr", addr1, 32'h0000_0304);
    checkOutput("bp_next_wdata", wdata1, 32'hFFF1_0113);
    step();
    checkOutput("bp_done", {31'h0, done1}, 32'h1);
    checkOutput("bp_count", {16'h0, count1}, 32'd2);
    checkOutput("bp_write_total", wrAddr1.size() - mark, 32'd2);
    checkWrite(0, mark + 0, 32'h0000_0300, 32'h0031_40B3);
    checkWrite(0, mark + 1, 32'h0000_0304, 32'hFFF1_0113);

    $display("[TB] illegal input");
    step();
    mark = wrAddr1.size();
    pulseStart(32'h0000_0400);
    applyStimulus(0, 3'd1, 4'b0010, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 0);
    checkOutput("ill_addi_we", {31'h0, we1}, 32'h0);
    checkOutput("ill_addi_err", {31'h0, err1}, 32'h1);
    applyStimulus(0, 3'd4, 4'b0000, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3, 0);
    checkOutput("ill_br_we", {31'h0, we1}, 32'h0);
    checkOutput("ill_br_addr", addr1, 32'h0000_0400);
    applyStimulus(0, 3'd0, 4'b0010, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1);
    step();
    checkOutput("ill_done", {31'h0, done1}, 32'h1);
    checkOutput("ill_count", {16'h0, count1}, 32'd1);
    checkOutput("ill_err", {31'h0, err1}, 32'h1);
    checkOutput("ill_err_index", {16'h0, errIndex1}, 32'd0);
    checkOutput("ill_write_total", wrAddr1.size() - mark, 32'd1);
    checkWrite(0, mark + 0, 32'h0000_0400, 32'h0020_81B3);

    $display("[TB] ignored start and illegal last");
    step();
    pulseStart(32'h0000_0500);
    checkOutput("restart_err_clear", {31'h0, err1}, 32'h0);
    applyStimulus(0, 3'd0, 4'b0010, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
    pulseStart(32'h0000_0900);
    checkOutput("ign_start_addr", addr1, 32'h0000_0504);
    checkOutput("ign_start_count", {16'h0, count1}, 32'd1);
    applyStimulus(0, 3'd1, 4'b0100, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1, 1);
    checkOutput("ill_last_err", {31'h0, err1}, 32'h1);
    checkOutput("ill_last_err_index", {16'h0, errIndex1}, 32'd1);
    checkOutput("ill_last_we", {31'h0, we1}, 32'h0);
    step();
    checkOutput("ill_last_done", {31'h0, done1}, 32'h1);
    checkOutput("ill_last_idle", {31'h0, busy1}, 32'h0);
    step();

    $display("[TB] address wrap");
    start2    = 1'b1;
    baseAddr2 = 8'hFC;
    step();
    start2 = 1'b0;
    applyStimulus(1, 3'd0, 4'b0010, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
    applyStimulus(1, 3'd1, 4'b0010, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    step();
    checkOutput("wrap_done", {31'h0, done2}, 32'h1);
    checkOutput("wrap_count", {16'h0, count2}, 32'd2);
    checkWrite(1, 0, 32'h0000_00FC, 32'h0020_81B3);
    checkWrite(1, 1, 32'h0000_0000, 32'h0050_0093);

    $display("[TB] reset mid-run");
    step();
    pulseStart(32'h0000_0600);
    applyStimulus(0, 3'd0, 4'b0010, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
    applyStimulus(0, 3'd1, 4'b0010, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0);
    imemReady = 1'b0;
    checkOutput("pre_rst_we", {31'h0, we1}, 32'h1);
    checkOutput("pre_rst_count", {16'h0, count1}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_we", {31'h0, we1}, 32'h0);
    checkOutput("mid_rst_busy", {31'h0, busy1}, 32'h0);
    checkOutput("mid_rst_count", {16'h0, count1}, 32'd0);
    checkOutput("mid_rst_addr", addr1, 32'h0);
    checkOutput("mid_rst_wdata", wdata1, 32'h0);
    step();
    rst_n     = 1'b1;
    imemReady = 1'b1;
    step();
    checkOutput("post_rst_in_ready", {31'h0, inReady1}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
